// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared 640x480 text-mode timing constants and cell geometry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_H_ACTIVE   = 640;
    localparam int c_V_ACTIVE   = 480;
    localparam int c_H_TOTAL    = 800;
    localparam int c_V_TOTAL    = 525;
    localparam int c_COLS       = 80;
    // log2 of the 8-pixel cell width and height
    localparam int c_CELL_SHIFT = 3;

endpackage

`default_nettype wire

// File: rtl/req_fifo.sv
// ============================================================================
// Module : req_fifo
// Brief  : Synchronous power-of-two FIFO holding queued CPU VRAM requests.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module : vram_arbiter
// Brief  : Shares the single-port text VRAM between scanout prefetch (fixed
//          priority slot) and queued CPU reads/writes; drives the pixel out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int H_TOTAL    = c_H_TOTAL,
    parameter int V_TOTAL    = c_V_TOTAL,
    parameter int COLS       = c_COLS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] pix
);

    localparam int c_ENTRY_W = 1 + ADDR_W + DATA_W;

    logic [10:0]          w_x_plus2;
    logic                 w_hwrap;
    logic [9:0]           w_nx;
    logic [9:0]           w_ny;
    logic                 w_slot;
    logic [ADDR_W-1:0]    w_scan_addr;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_head_we;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_wdata;

    logic [ADDR_W-1:0]    r_addr_hold;
    logic                 r_scan_pend;
    logic                 r_rd_pend;
    logic                 r_cpu_rvalid;
    logic [DATA_W-1:0]    r_cpu_rdata;
    logic [DATA_W-1:0]    r_cell;

    // Look two pixels ahead: one cycle for RAM latency, one for the cell latch
    always_comb begin
        w_x_plus2 = {1'b0, x} + 11'd2;
        w_hwrap   = (w_x_plus2 >= 11'(H_TOTAL));
        w_nx      = w_hwrap ? 10'(w_x_plus2 - 11'(H_TOTAL)) : w_x_plus2[9:0];
        if (!w_hwrap)
            w_ny = y;
        else if (y == 10'(V_TOTAL - 1))
            w_ny = '0;
        else
            w_ny = y + 10'd1;
    end

    assign w_slot = (w_nx[c_CELL_SHIFT-1:0] == '0) &&
                    (w_nx < 10'(H_ACTIVE)) && (w_ny < 10'(V_ACTIVE));

    assign w_scan_addr = ADDR_W'(w_nx >> c_CELL_SHIFT) +
                         ADDR_W'(w_ny >> c_CELL_SHIFT) * ADDR_W'(COLS);

    assign cpu_ready    = ~w_full;
    assign w_push       = cpu_valid & ~w_full;
    assign w_push_entry = {cpu_we, cpu_addr, cpu_wdata};
    assign w_pop        = ~w_slot & ~w_empty;

    assign w_head_we    = w_head[c_ENTRY_W-1];
    assign w_head_addr  = w_head[DATA_W +: ADDR_W];
    assign w_head_wdata = w_head[DATA_W-1:0];

    req_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (CLK),
        .rst         (RST),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        ram_addr  = r_addr_hold;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_slot) begin
            ram_addr = w_scan_addr;
        end else if (w_pop) begin
            ram_addr  = w_head_addr;
            ram_we    = w_head_we;
            ram_wdata = w_head_wdata;
        end
    end

    // Return pipe: the RAM answers one cycle after the address is sampled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr_hold  <= '0;
            r_scan_pend  <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cell       <= '0;
        end else begin
            r_addr_hold  <= ram_addr;
            r_scan_pend  <= w_slot;
            r_rd_pend    <= w_pop & ~w_head_we;
            r_cpu_rvalid <= r_rd_pend;
            if (r_scan_pend) r_cell      <= ram_q;
            if (r_rd_pend)   r_cpu_rdata <= ram_q;
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign pix        = ((x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE))) ? r_cell : '0;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module : tb_vram_arbiter
// Brief  : Directed self-checking bench for vram_arbiter with a VRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [9:0]        x = 10'd100;
    logic [9:0]        y = 10'd100;
    logic              cpu_valid = 1'b0;
    logic              cpu_ready;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q = '0;
    logic [DATA_W-1:0] pix;

    logic [DATA_W-1:0] mem [0:8191];

    int n_tests = 0;
    int n_fail  = 0;

    vram_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .x          (x),
        .y          (y),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_q      (ram_q),
        .pix        (pix)
    );

    always #5 CLK = ~CLK;

    // Single-port synchronous VRAM, read-before-write
    always @(posedge CLK) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (x == 10'd799) begin
            x = 10'd0;
            y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        #1;
    endtask

    task automatic place(input logic [9:0] xx, input logic [9:0] yy);
        @(posedge CLK);
        #1;
        x = xx;
        y = yy;
        #1;
    endtask

    task automatic hold();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid); end
        n_tests++; if (cpu_rdata !== 3'd0) begin n_fail++; $display("FAIL reset_rdata: got %0d want 0", cpu_rdata); end
        n_tests++; if (pix !== 3'd0) begin n_fail++; $display("FAIL reset_pix: got %0d want 0", pix); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", ram_we); end
    endtask

    task automatic test_scanout_first_cell();
        place(10'd798, 10'd524);
        n_tests++; if (ram_addr !== 13'd0) begin n_fail++; $display("FAIL first_fetch_addr: got %0d want 0", ram_addr); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL first_fetch_we: got %b want 0", ram_we); end
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (pix !== 3'b101) begin n_fail++; $display("FAIL cell0_pix x=%0d: got %b want 101", x, pix); end
            tick();
        end
        place(10'd640, 10'd0);
        for (int i = 0; i < 160; i++) begin
            n_tests++; if (pix !== 3'd0) begin n_fail++; $display("FAIL blank_pix x=%0d: got %b want 000", x, pix); end
            tick();
        end
    endtask

    task automatic test_cell_addr();
        place(10'd158, 10'd17);
        n_tests++; if (ram_addr !== 13'd180) begin n_fail++; $display("FAIL cell_addr_17_158: got %0d want 180", ram_addr); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL cell_we_17_158: got %b want 0", ram_we); end
        place(10'd630, 10'd479);
        n_tests++; if (ram_addr !== 13'd4799) begin n_fail++; $display("FAIL cell_addr_479_630: got %0d want 4799", ram_addr); end
    endtask

    task automatic test_write_read();
        place(10'd100, 10'd500);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 3'b110;
        tick();
        n_tests++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", ram_we); end
        n_tests++; if (ram_addr !== 13'h1234) begin n_fail++; $display("FAIL wr_addr: got %h want 1234", ram_addr); end
        n_tests++; if (ram_wdata !== 3'b110) begin n_fail++; $display("FAIL wr_data: got %b want 110", ram_wdata); end
        cpu_we = 1'b0;
        tick();
        cpu_valid = 1'b0;
        n_tests++; if (ram_we !== 1'b0 || ram_addr !== 13'h1234) begin n_fail++; $display("FAIL rd_grant: got we=%b addr=%h want we=0 addr=1234", ram_we, ram_addr); end
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_g: got %b want 0", cpu_rvalid); end
        tick();
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_g1: got %b want 0", cpu_rvalid); end
        tick();
        n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 3'b110) begin n_fail++; $display("FAIL rd_return: got v=%b d=%b want v=1 d=110", cpu_rvalid, cpu_rdata); end
        tick();
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_end: got %b want 0", cpu_rvalid); end
    endtask

    task automatic test_back_to_back();
        place(10'd200, 10'd500);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd10;
        tick();
        cpu_addr = 13'd11;
        tick();
        cpu_valid = 1'b0;
        tick();
        n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 3'd3) begin n_fail++; $display("FAIL b2b_first: got v=%b d=%0d want v=1 d=3", cpu_rvalid, cpu_rdata); end
        tick();
        n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 3'd4) begin n_fail++; $display("FAIL b2b_second: got v=%b d=%0d want v=1 d=4", cpu_rvalid, cpu_rdata); end
        tick();
        n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", cpu_rvalid); end
    endtask

    task automatic test_collision();
        place(10'd101, 10'd100);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd256; cpu_wdata = 3'b111;
        tick();
        cpu_valid = 1'b0; cpu_we = 1'b0;
        n_tests++; if (ram_addr !== 13'd973 || ram_we !== 1'b0) begin n_fail++; $display("FAIL coll_slot: got addr=%0d we=%b want addr=973 we=0", ram_addr, ram_we); end
        tick();
        n_tests++; if (ram_we !== 1'b1 || ram_addr !== 13'd256 || ram_wdata !== 3'b111) begin n_fail++; $display("FAIL coll_write: got we=%b addr=%0d d=%b want we=1 addr=256 d=111", ram_we, ram_addr, ram_wdata); end
        tick();
        n_tests++; if (pix !== 3'b010) begin n_fail++; $display("FAIL coll_pix: got %b want 010", pix); end
    endtask

    task automatic test_full();
        place(10'd102, 10'd100);
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_pre%0d: got %b want 1", i, cpu_ready); end
            cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 13'(20 + i);
            hold();
        end
        n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after4: got %b want 0", cpu_ready); end
        cpu_addr = 13'd24;
        hold();
        cpu_valid = 1'b0;
        n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_5th: got %b want 0", cpu_ready); end
        place(10'd100, 10'd500);
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop0: got %b want 0", cpu_ready); end
            end
            if (k == 1) begin
                n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_pop1: got %b want 1", cpu_ready); end
            end
            if (k < 4) begin
                n_tests++; if (ram_addr !== 13'(20 + k)) begin n_fail++; $display("FAIL full_order%0d: got %0d want %0d", k, ram_addr, 20 + k); end
            end
            if (k == 4) begin
                n_tests++; if (ram_addr !== 13'd23) begin n_fail++; $display("FAIL full_idle_hold: got %0d want 23", ram_addr); end
            end
            if (k >= 2 && k < 6) begin
                n_tests++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 3'(k - 1)) begin n_fail++; $display("FAIL full_rdata%0d: got v=%b d=%0d want v=1 d=%0d", k, cpu_rvalid, cpu_rdata, k - 1); end
            end
            if (k == 6) begin
                n_tests++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL full_no_5th: got %b want 0", cpu_rvalid); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        place(10'd102, 10'd100);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd30;
        hold();
        cpu_we = 1'b1; cpu_addr = 13'h1F00; cpu_wdata = 3'b001;
        hold();
        cpu_addr = 13'h1F01;
        hold();
        cpu_valid = 1'b0; cpu_we = 1'b0;
        place(10'd100, 10'd500);
        n_tests++; if (ram_addr !== 13'd30) begin n_fail++; $display("FAIL rstmid_grant: got %0d want 30", ram_addr); end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", cpu_ready); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_tests++; if (cpu_rvalid !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet%0d: got v=%b we=%b want 0 0", i, cpu_rvalid, ram_we); end
            tick();
        end
        place(10'd0, 10'd0);
        for (int i = 0; i < 6; i++) begin
            n_tests++; if (pix !== 3'd0) begin n_fail++; $display("FAIL rstmid_pix x=%0d: got %b want 000", x, pix); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[0]   = 3'b101;
        mem[10]  = 3'd3;
        mem[11]  = 3'd4;
        mem[973] = 3'b010;
        mem[20]  = 3'd1;
        mem[21]  = 3'd2;
        mem[22]  = 3'd3;
        mem[23]  = 3'd4;
        mem[24]  = 3'd5;
        mem[30]  = 3'd6;

        test_reset();
        test_scanout_first_cell();
        test_cell_addr();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_full();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
